// File: rtl/rf_pkg.sv
// rf_pkg: shared defaults, register-file types and the popcount helper.
package rf_pkg;
  localparam int RF_DATA_W = 16;
  localparam int RF_NUM_REGS = 8;
  localparam int RF_MAX_REGS = 1024;
  typedef logic [$clog2(RF_NUM_REGS)-1:0] rf_addr_t;
  typedef logic [RF_DATA_W-1:0] rf_data_t;
  function automatic int popcount(input logic [RF_MAX_REGS-1:0] v);
    int c;
    c = 0;
    for (int i = 0; i < RF_MAX_REGS; i++) c += int'(v[i]);
    return c;
  endfunction
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register pending-write bits and registered busy count.
// RF_ZERO_REG_EN keeps register 0 permanently not busy.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NUM_REGS = RF_NUM_REGS,
  localparam int ADDR_W = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_en,
  input  logic [ADDR_W-1:0]   issue_addr,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  output logic [NUM_REGS-1:0] busy,
  output logic [ADDR_W:0]     busy_cnt
);
  localparam int CNT_W = ADDR_W + 1;
  logic [NUM_REGS-1:0] busy_d;
  // A new producer wins over a retiring one on the same register.
  always_comb begin
    busy_d = busy;
    for (int i = 0; i < NUM_REGS; i++)
      busy_d[i] = (issue_en && issue_addr == ADDR_W'(i)) ? 1'b1 :
                  (wr_en && wr_addr == ADDR_W'(i)) ? 1'b0 : busy[i];
`ifdef RF_ZERO_REG_EN
    busy_d[0] = 1'b0;
`endif
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
      busy_cnt <= '0;
    end else begin
      busy <= busy_d;
      busy_cnt <= CNT_W'(popcount(RF_MAX_REGS'(busy_d)));
    end
  end
endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: 2R/1W register file with write bypass and pending-write scoreboard.
// RF_ZERO_REG_EN hardwires register 0 to zero.
module reg_file_sb
  import rf_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int NUM_REGS = RF_NUM_REGS,
  localparam int ADDR_W = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_busy1,
  output logic              rd_busy2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr,
  output logic [ADDR_W:0]   busy_cnt
);
  logic [DATA_W-1:0] mem [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic wr_ok;
  rf_scoreboard #(.NUM_REGS(NUM_REGS)) u_sb (
    .clk(clk), .rst(rst), .issue_en(issue_en), .issue_addr(issue_addr),
    .wr_en(wr_en), .wr_addr(wr_addr), .busy(busy), .busy_cnt(busy_cnt)
  );
  // Dropping writes to r0 also suppresses its bypass, so r0 always reads 0.
`ifdef RF_ZERO_REG_EN
  assign wr_ok = wr_en && wr_addr != '0;
`else
  assign wr_ok = wr_en;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end
  always_comb begin
    rd_data1 = (wr_ok && wr_addr == rd_addr1) ? wr_data : mem[rd_addr1];
    rd_data2 = (wr_ok && wr_addr == rd_addr2) ? wr_data : mem[rd_addr2];
    rd_busy1 = busy[rd_addr1] && !(wr_en && wr_addr == rd_addr1);
    rd_busy2 = busy[rd_addr2] && !(wr_en && wr_addr == rd_addr2);
  end
endmodule
